// File: rtl/ea_sequencer.sv
// Effective-address engine for direct, indirect and auto-index memory-reference instructions.
// Define AUTOINDEX_EN to build the auto-index read-modify-write path (AUT_INC/AUT_WR).
module ea_sequencer #(
    parameter int WORD_W  = 12,
    parameter int OFF_W   = 7,
    parameter int AUTO_LO = 8,
    parameter int AUTO_HI = 15,
    parameter int TIMEOUT = 64
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [WORD_W-1:0] ir_i,
    input  logic [WORD_W-1:0] pc_i,
    output logic [WORD_W-1:0] mem_addr_o,
    output logic              mem_rd_o,
    output logic              mem_wr_o,
    output logic [WORD_W-1:0] mem_wdata_o,
    input  logic [WORD_W-1:0] mem_rdata_i,
    input  logic              mem_done_i,
    output logic [WORD_W-1:0] ea_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              auto_hit_o
);

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        IND_RD,
`ifdef AUTOINDEX_EN
        AUT_INC,
        AUT_WR,
`endif
        DONE,
        ERR
    } state_e;

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [WORD_W-1:0] AUTO_LO_W = WORD_W'(AUTO_LO);
    localparam logic [WORD_W-1:0] AUTO_HI_W = WORD_W'(AUTO_HI);

    state_e            state_q, state_d;
    logic [WORD_W-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0] ea_q, ea_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
`ifdef AUTOINDEX_EN
    logic [WORD_W-1:0] tmp_q, tmp_d;
    logic              auto_q, auto_d;
`endif

    logic [WORD_W-1:0] dir;
    logic              indirect;
    logic              in_auto;
    logic              timed_out;
    logic              unused_bits;

    // Page-zero or current-page address straight from the instruction.
    always_comb begin
        dir      = {{(WORD_W-OFF_W){1'b0}}, ir_i[OFF_W-1:0]};
        indirect = ir_i[OFF_W+1];
        if (ir_i[OFF_W]) begin
            dir = {pc_i[WORD_W-1:OFF_W], ir_i[OFF_W-1:0]};
        end
    end

    // mem_addr_q still holds the pointer address while the defer read is in flight.
    assign in_auto   = (mem_addr_q >= AUTO_LO_W) && (mem_addr_q <= AUTO_HI_W);
    assign timed_out = (TIMEOUT > 0) && (cnt_q == CNT_LAST);

`ifdef AUTOINDEX_EN
    assign unused_bits = ^{ir_i[WORD_W-1:OFF_W+2], pc_i[OFF_W-1:0]};
`else
    assign unused_bits = ^{ir_i[WORD_W-1:OFF_W+2], pc_i[OFF_W-1:0], in_auto};
`endif

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            mem_addr_q <= '0;
            ea_q       <= '0;
            cnt_q      <= '0;
`ifdef AUTOINDEX_EN
            tmp_q      <= '0;
            auto_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            ea_q       <= ea_d;
            cnt_q      <= cnt_d;
`ifdef AUTOINDEX_EN
            tmp_q      <= tmp_d;
            auto_q     <= auto_d;
`endif
        end
    end

    // The wait counter idles at zero so it is already clear on entry to a request state.
    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        ea_d       = ea_q;
        cnt_d      = '0;
`ifdef AUTOINDEX_EN
        tmp_d      = tmp_q;
        auto_d     = auto_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = CALC;
                end
            end
            CALC: begin
`ifdef AUTOINDEX_EN
                auto_d = 1'b0;
`endif
                if (indirect) begin
                    mem_addr_d = dir;
                    state_d    = IND_RD;
                end else begin
                    ea_d    = dir;
                    state_d = DONE;
                end
            end
            IND_RD: begin
                if (mem_done_i) begin
`ifdef AUTOINDEX_EN
                    if (in_auto) begin
                        tmp_d   = mem_rdata_i;
                        auto_d  = 1'b1;
                        state_d = AUT_INC;
                    end else begin
                        ea_d    = mem_rdata_i;
                        state_d = DONE;
                    end
`else
                    ea_d    = mem_rdata_i;
                    state_d = DONE;
`endif
                end else if (timed_out) begin
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef AUTOINDEX_EN
            AUT_INC: begin
                tmp_d   = tmp_q + 1'b1;
                state_d = AUT_WR;
            end
            AUT_WR: begin
                if (mem_done_i) begin
                    ea_d    = tmp_q;
                    state_d = DONE;
                end else if (timed_out) begin
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            DONE: state_d = IDLE;
            ERR:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign mem_addr_o = mem_addr_q;
    assign mem_rd_o   = (state_q == IND_RD);
    assign ea_o       = ea_q;
    assign busy_o     = (state_q != IDLE);
    assign done_o     = (state_q == DONE);
    assign err_o      = (state_q == ERR);

`ifdef AUTOINDEX_EN
    assign mem_wr_o    = (state_q == AUT_WR);
    assign mem_wdata_o = (state_q == AUT_WR) ? tmp_q : '0;
    assign auto_hit_o  = (state_q == DONE) && auto_q;
`else
    assign mem_wr_o    = 1'b0;
    assign mem_wdata_o = '0;
    assign auto_hit_o  = 1'b0;
`endif

endmodule

// File: tb/tb_ea_sequencer.sv
// Scoreboard bench for ea_sequencer: a memory model answers requests, a monitor checks each result.
// Builds against either configuration of AUTOINDEX_EN.
module tb_ea_sequencer;

    localparam int W   = 12;
    localparam int TMO = 8;

    typedef struct {
        logic [W-1:0] ea;
        bit           autoHit;
        bit           isErr;
    } expTxn_t;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] ir;
    logic [W-1:0] pc;
    logic [W-1:0] memAddr;
    logic         memRd;
    logic         memWr;
    logic [W-1:0] memWdata;
    logic [W-1:0] memRdata = '0;
    logic         memDone = 1'b0;
    logic [W-1:0] ea;
    logic         busy;
    logic         done;
    logic         err;
    logic         autoHit;

    logic [W-1:0] mem [0:4095];
    int           rdDelay = 0;
    int           wrDelay = 0;
    int           reqCycles = 0;
    int           rdCycles = 0;
    int           wrCycles = 0;
    int           checkCount = 0;
    int           passCount = 0;
    logic [W-1:0] lastEa = '0;
    expTxn_t      expQ[$];

    ea_sequencer #(
        .WORD_W (W),
        .OFF_W  (7),
        .AUTO_LO(8),
        .AUTO_HI(15),
        .TIMEOUT(TMO)
    ) dut (
        .clock_i    (clock),
        .reset_i    (reset),
        .start_i    (start),
        .ir_i       (ir),
        .pc_i       (pc),
        .mem_addr_o (memAddr),
        .mem_rd_o   (memRd),
        .mem_wr_o   (memWr),
        .mem_wdata_o(memWdata),
        .mem_rdata_i(memRdata),
        .mem_done_i (memDone),
        .ea_o       (ea),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err),
        .auto_hit_o (autoHit)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed %0o expected %0o", tag, observed, expected);
        end
    endtask

    // Memory model: a delay of -1 never answers; mem_done toggles randomly while nothing is requested.
    always @(negedge clock) begin
        int dly;
        if (memRd || memWr) begin
            dly = memRd ? rdDelay : wrDelay;
            memDone = (dly >= 0) && (reqCycles == dly);
            memRdata = mem[memAddr];
            if (memWr && memDone) begin
                mem[memAddr] = memWdata;
            end
            reqCycles++;
        end else begin
            memDone = 1'($urandom_range(0, 1));
            memRdata = W'($urandom);
            reqCycles = 0;
        end
    end

    always @(negedge clock) begin
        expTxn_t t;
        if (memRd) rdCycles++;
        if (memWr) wrCycles++;
        if (done || err) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_result", {done, err}, 0);
            end else begin
                t = expQ.pop_front();
                checkOutput("done", done, !t.isErr);
                checkOutput("err", err, t.isErr);
                checkOutput("ea", ea, t.ea);
                checkOutput("auto_hit", autoHit, t.autoHit);
            end
        end
    end

    task automatic applyStimulus(input logic [W-1:0] irVal, input logic [W-1:0] pcVal,
                                 input int rdDly, input int wrDly, input bit poke);
        logic [W-1:0] dir;
        logic [W-1:0] memOld;
        logic [W-1:0] expWb;
        expTxn_t      t;
        bit           isInd;
        bit           isAuto;
        bit           seen;
        int           expLat;
        int           expRd;
        int           expWr;
        int           edges;
        isInd  = irVal[8];
        dir    = irVal[7] ? {pcVal[11:7], irVal[6:0]} : {5'b0, irVal[6:0]};
        isAuto = 1'b0;
`ifdef AUTOINDEX_EN
        isAuto = isInd && (dir >= 12'o10) && (dir <= 12'o17);
`endif
        memOld    = mem[dir];
        expWb     = memOld + 1'b1;
        t.ea      = lastEa;
        t.autoHit = 1'b0;
        t.isErr   = 1'b0;
        expRd     = 0;
        expWr     = 0;
        if (!isInd) begin
            t.ea = dir;
            expLat = 2;
        end else if (rdDly < 0) begin
            t.isErr = 1'b1;
            expLat = 2 + TMO;
            expRd = TMO;
        end else if (!isAuto) begin
            t.ea = memOld;
            expLat = 3 + rdDly;
            expRd = rdDly + 1;
        end else if (wrDly < 0) begin
            t.isErr = 1'b1;
            expLat = 4 + rdDly + TMO;
            expRd = rdDly + 1;
            expWr = TMO;
        end else begin
            t.ea = expWb;
            t.autoHit = 1'b1;
            expLat = 5 + rdDly + wrDly;
            expRd = rdDly + 1;
            expWr = wrDly + 1;
        end

        @(negedge clock);
        rdDelay  = rdDly;
        wrDelay  = wrDly;
        rdCycles = 0;
        wrCycles = 0;
        ir       = irVal;
        pc       = pcVal;
        start    = 1'b1;
        expQ.push_back(t);
        if (!t.isErr) lastEa = t.ea;

        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 300) begin
            @(posedge clock);
            edges++;
            @(negedge clock);
            start = poke && (edges == 2);
            if (edges == 1) checkOutput("busy_after_start", busy, 1);
            if (done || err) seen = 1'b1;
        end
        start = 1'b0;
        if (!seen) begin
            checkOutput("result_wait", 0, 1);
            expQ.delete();
        end
        checkOutput("latency", edges, expLat);
        checkOutput("rd_cycles", rdCycles, expRd);
        checkOutput("wr_cycles", wrCycles, expWr);
        if (isAuto && !t.isErr) checkOutput("mem_writeback", mem[dir], expWb);

        @(negedge clock);
        checkOutput("pulse_end", {done, err}, 0);
        checkOutput("idle_after", busy, 0);
    endtask

    // Reset lands while a request is outstanding; nothing may be written and all state clears.
    task automatic abortTest();
        logic [W-1:0] memOld;
        bit           reached;
        @(negedge clock);
`ifdef AUTOINDEX_EN
        rdDelay = 0;
        wrDelay = -1;
        ir      = 12'o1410;
`else
        rdDelay = -1;
        wrDelay = -1;
        ir      = 12'o1420;
`endif
        pc      = 12'o0000;
        memOld  = mem[ir[6:0]];
        start   = 1'b1;
        reached = 1'b0;
        for (int n = 0; n < 20 && !reached; n++) begin
            @(posedge clock);
            @(negedge clock);
            start = 1'b0;
`ifdef AUTOINDEX_EN
            reached = memWr;
`else
            reached = memRd;
`endif
        end
        checkOutput("abort_reach", reached, 1);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        checkOutput("abort_rd", memRd, 0);
        checkOutput("abort_wr", memWr, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_ea", ea, 0);
        checkOutput("abort_addr", memAddr, 0);
        checkOutput("abort_mem", mem[ir[6:0]], memOld);
        reset  = 1'b0;
        lastEa = '0;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = W'($urandom);
        mem[12'o0020] = 12'o5555;
        mem[12'o0010] = 12'o7777;
        mem[12'o0011] = 12'o0123;
        reset = 1'b1;
        start = 1'b0;
        ir    = '0;
        pc    = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_pulses", {done, err, autoHit}, 0);
        checkOutput("reset_ea", ea, 0);
        checkOutput("reset_addr", memAddr, 0);
        checkOutput("reset_req", {memRd, memWr}, 0);
        checkOutput("reset_wdata", memWdata, 0);
        reset = 1'b0;

        applyStimulus(12'o1323, 12'o4200, 0, 0, 0);
        applyStimulus(12'o0055, 12'o7600, 0, 0, 0);
        applyStimulus(12'o1420, 12'o0000, 0, 0, 0);
        applyStimulus(12'o1620, 12'o3000, 3, 0, 0);
        applyStimulus(12'o1420, 12'o0000, TMO - 1, 0, 0);
        applyStimulus(12'o1420, 12'o0000, -1, 0, 0);
        applyStimulus(12'o1410, 12'o0000, 0, 0, 0);
        applyStimulus(12'o1411, 12'o0000, 0, 0, 0);
        applyStimulus(12'o1407, 12'o0000, 1, 1, 0);
        applyStimulus(12'o1417, 12'o0000, 2, 1, 0);
        applyStimulus(12'o1420, 12'o0000, 2, 0, 1);
`ifdef AUTOINDEX_EN
        applyStimulus(12'o1412, 12'o0000, 1, -1, 0);
        applyStimulus(12'o1413, 12'o0000, 1, 2, 1);
`endif
        for (int k = 0; k < 8; k++) begin
            applyStimulus(W'($urandom), W'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), 0);
        end
        abortTest();
        applyStimulus(12'o1420, 12'o0000, 0, 0, 0);

        checkOutput("queue_empty", expQ.size(), 0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
